// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the EX/MA stage, the memory access controller and data memory.
// Handshake: MEM_REQ rises with MEM_WE/MEM_SIZE/MEM_ADDR/MEM_WDATA and holds them stable until the edge that sees MEM_ACK=1.
interface mem_access_ctrl_if;
  logic [1:0]  MEM_READ;
  logic [1:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] LOAD_DATA;
  logic        STALL;
  logic        MISALIGN_ERR;
  logic        ILLEGAL_ERR;
  logic        TIMEOUT_ERR;

  modport master (
    input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_ACK, MEM_RDATA,
    output MEM_REQ, MEM_WE, MEM_SIZE, MEM_ADDR, MEM_WDATA, LOAD_DATA,
    output STALL, MISALIGN_ERR, ILLEGAL_ERR, TIMEOUT_ERR
  );

  modport slave (
    output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_ACK, MEM_RDATA,
    input  MEM_REQ, MEM_WE, MEM_SIZE, MEM_ADDR, MEM_WDATA, LOAD_DATA,
    input  STALL, MISALIGN_ERR, ILLEGAL_ERR, TIMEOUT_ERR
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: validates loads/stores, issues one registered request
// to data memory, stalls the pipeline until ack or timeout. DBG_STATE: 0 IDLE, 1 REQ, 2 DONE.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_access_ctrl_if.master bus,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;

  logic        rd_req;
  logic        wr_req;
  logic        both_req;
  logic        one_req;
  logic [1:0]  acc_size;
  logic        aligned;

  logic        start;
  logic        ack_take;
  logic        timeout_hit;
  logic        misalign_hit;
  logic        illegal_hit;
  logic        stall;

  // Access decode from the EX/MA register fields.
  always_comb begin
    rd_req   = |bus.MEM_READ;
    wr_req   = |bus.MEM_WRITE;
    both_req = rd_req & wr_req;
    one_req  = rd_req ^ wr_req;
    acc_size = rd_req ? bus.MEM_READ : bus.MEM_WRITE;
    case (acc_size)
      2'b10:   aligned = ~bus.ADDRESS[0];
      2'b11:   aligned = (bus.ADDRESS[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    ack_take     = 1'b0;
    timeout_hit  = 1'b0;
    misalign_hit = 1'b0;
    illegal_hit  = 1'b0;
    stall        = 1'b0;
    case (state)
      IDLE: begin
        // Illegal wins over misaligned; neither launches a request.
        if (both_req) begin
          illegal_hit = 1'b1;
        end else if (one_req && !aligned) begin
          misalign_hit = 1'b1;
        end else if (one_req) begin
          start     = 1'b1;
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.MEM_ACK) begin
          ack_take  = 1'b1;
          state_nxt = DONE;
        end else begin
          stall = 1'b1;
          if (wait_cnt == LAST_WAIT) begin
            timeout_hit = 1'b1;
            state_nxt   = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!RESET) begin
      stall = 1'b0;
    end
  end

  assign bus.STALL = stall;
  assign DBG_STATE = state;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wait_cnt         <= 8'd0;
      bus.MEM_REQ      <= 1'b0;
      bus.MEM_WE       <= 1'b0;
      bus.MEM_SIZE     <= 2'b00;
      bus.MEM_ADDR     <= 32'd0;
      bus.MEM_WDATA    <= 32'd0;
      bus.LOAD_DATA    <= 32'd0;
      bus.MISALIGN_ERR <= 1'b0;
      bus.ILLEGAL_ERR  <= 1'b0;
      bus.TIMEOUT_ERR  <= 1'b0;
    end else begin
      bus.MISALIGN_ERR <= misalign_hit;
      bus.ILLEGAL_ERR  <= illegal_hit;
      bus.TIMEOUT_ERR  <= timeout_hit;
      if (start) begin
        wait_cnt      <= 8'd0;
        bus.MEM_REQ   <= 1'b1;
        bus.MEM_WE    <= wr_req;
        bus.MEM_SIZE  <= acc_size;
        bus.MEM_ADDR  <= bus.ADDRESS;
        bus.MEM_WDATA <= bus.WRITE_DATA;
      end else if (ack_take || timeout_hit) begin
        bus.MEM_REQ <= 1'b0;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // Request attributes stay held after completion; only load data is captured.
      if (ack_take && !bus.MEM_WE) begin
        bus.LOAD_DATA <= bus.MEM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level model checked every cycle,
// an address scoreboard for issued requests, and literal expectations per scenario.
module tb_mem_access_ctrl;
  localparam int T = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] DBG_STATE;
  bit         chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .DBG_STATE (DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 none, 1 valid, 2 misaligned, 3 illegal
  function automatic int classify();
    int nbytes;
    logic [1:0] sz;
    if (bus.MEM_READ != 2'b00 && bus.MEM_WRITE != 2'b00) return 3;
    if (bus.MEM_READ == 2'b00 && bus.MEM_WRITE == 2'b00) return 0;
    sz = (bus.MEM_READ != 2'b00) ? bus.MEM_READ : bus.MEM_WRITE;
    nbytes = 1 << (int'(sz) - 1);
    return ((int'(bus.ADDRESS[1:0]) % nbytes) == 0) ? 1 : 2;
  endfunction

  // behavioural model: a request is either outstanding (busy), cooling down for one cycle, or absent
  bit          m_busy, m_cool, m_req, m_we, m_mis, m_ill, m_to;
  int          m_waited;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_load;

  always @(posedge CLK) begin
    m_mis = 1'b0;
    m_ill = 1'b0;
    m_to  = 1'b0;
    if (!RESET) begin
      m_busy = 0; m_cool = 0; m_req = 0; m_we = 0; m_waited = 0;
      m_size = 0; m_addr = 0; m_wdata = 0; m_load = 0;
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_busy) begin
      if (bus.MEM_ACK) begin
        m_busy = 0; m_req = 0; m_cool = 1;
        if (!m_we) m_load = bus.MEM_RDATA;
      end else if (m_waited == T - 1) begin
        m_busy = 0; m_req = 0; m_cool = 1; m_to = 1;
      end else begin
        m_waited++;
      end
    end else begin
      case (classify())
        1: begin
          m_busy = 1; m_req = 1; m_waited = 0;
          m_we    = (bus.MEM_WRITE != 2'b00);
          m_size  = m_we ? bus.MEM_WRITE : bus.MEM_READ;
          m_addr  = bus.ADDRESS;
          m_wdata = bus.WRITE_DATA;
        end
        2: m_mis = 1'b1;
        3: m_ill = 1'b1;
        default: ;
      endcase
    end
  end

  // scoreboard of request addresses the driver expects, plus per-scenario activity counters
  logic [31:0] exp_q[$];
  logic        prev_req = 1'b0;
  int req_hi, stall_hi, done_n, mis_n, ill_n, to_n;

  always @(negedge CLK) begin
    logic exp_stall;
    logic [1:0] exp_state;
    if (chk_en) begin
      exp_stall = RESET && ((!m_busy && !m_cool && classify() == 1) || (m_busy && !bus.MEM_ACK));
      exp_state = m_busy ? 2'd1 : (m_cool ? 2'd2 : 2'd0);
      chk("stall",     bus.STALL,        exp_stall);
      chk("state",     DBG_STATE,        exp_state);
      chk("mem_req",   bus.MEM_REQ,      m_req);
      chk("mem_we",    bus.MEM_WE,       m_we);
      chk("mem_size",  bus.MEM_SIZE,     m_size);
      chk("mem_addr",  bus.MEM_ADDR,     m_addr);
      chk("mem_wdata", bus.MEM_WDATA,    m_wdata);
      chk("load_data", bus.LOAD_DATA,    m_load);
      chk("misalign",  bus.MISALIGN_ERR, m_mis);
      chk("illegal",   bus.ILLEGAL_ERR,  m_ill);
      chk("timeout",   bus.TIMEOUT_ERR,  m_to);
      if (bus.MEM_REQ && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_unexpected: got request at %h required none", bus.MEM_ADDR);
        end else begin
          chk("req_addr_sb", bus.MEM_ADDR, exp_q.pop_front());
        end
      end
      prev_req = bus.MEM_REQ;
      if (bus.STALL)        stall_hi++;
      if (bus.MEM_REQ)      req_hi++;
      if (DBG_STATE == 2)   done_n++;
      if (bus.MISALIGN_ERR) mis_n++;
      if (bus.ILLEGAL_ERR)  ill_n++;
      if (bus.TIMEOUT_ERR)  to_n++;
    end
  end

  // driver tasks
  task automatic idle_in();
    bus.MEM_READ   = 2'b00;
    bus.MEM_WRITE  = 2'b00;
    bus.ADDRESS    = 32'd0;
    bus.WRITE_DATA = 32'd0;
    bus.MEM_ACK    = 1'b0;
    bus.MEM_RDATA  = 32'h1234_5678;
  endtask

  task automatic drive(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.MEM_READ   = rd;
    bus.MEM_WRITE  = wr;
    bus.ADDRESS    = addr;
    bus.WRITE_DATA = wdata;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr_cnt();
    req_hi = 0; stall_hi = 0; done_n = 0; mis_n = 0; ill_n = 0; to_n = 0;
  endtask

  initial begin
    idle_in();
    clr_cnt();
    RESET = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("rst_mem_req", bus.MEM_REQ, 0);
    chk("rst_load", bus.LOAD_DATA, 0);
    chk("rst_stall", bus.STALL, 0);
    RESET = 1'b1;
    tick(1);

    // word load, ack in third REQ cycle
    clr_cnt();
    drive(2'b11, 2'b00, 32'h100, 32'h0);
    exp_q.push_back(32'h100);
    tick(3);
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 32'hDEAD_BEEF;
    tick(1);
    idle_in();
    tick(3);
    chk("wl_req_cycles", req_hi, 3);
    chk("wl_stall_cycles", stall_hi, 3);
    chk("wl_done_cycles", done_n, 1);
    chk("wl_load", bus.LOAD_DATA, 32'hDEAD_BEEF);
    chk("wl_addr", bus.MEM_ADDR, 32'h100);

    // byte store at odd address, immediate ack
    clr_cnt();
    drive(2'b00, 2'b01, 32'h203, 32'h55);
    exp_q.push_back(32'h203);
    tick(1);
    chk("bs_we", bus.MEM_WE, 1);
    chk("bs_size", bus.MEM_SIZE, 2'b01);
    chk("bs_wdata", bus.MEM_WDATA, 32'h55);
    idle_in();
    bus.MEM_ACK = 1'b1;
    tick(1);
    idle_in();
    tick(2);
    chk("bs_stall_cycles", stall_hi, 1);
    chk("bs_load_kept", bus.LOAD_DATA, 32'hDEAD_BEEF);

    // misaligned half load
    clr_cnt();
    drive(2'b10, 2'b00, 32'h101, 32'h0);
    tick(1);
    idle_in();
    tick(2);
    chk("mis_pulses", mis_n, 1);
    chk("mis_req_cycles", req_hi, 0);
    chk("mis_stall_cycles", stall_hi, 0);

    // read and write together, also misaligned: illegal wins
    clr_cnt();
    drive(2'b11, 2'b10, 32'h101, 32'h0);
    tick(1);
    idle_in();
    tick(2);
    chk("ill_pulses", ill_n, 1);
    chk("ill_no_misalign", mis_n, 0);
    chk("ill_req_cycles", req_hi, 0);

    // word store that never gets an ack
    clr_cnt();
    drive(2'b00, 2'b11, 32'h40, 32'hCAFE_F00D);
    exp_q.push_back(32'h40);
    tick(5);
    idle_in();
    tick(2);
    chk("to_req_cycles", req_hi, T);
    chk("to_pulses", to_n, 1);
    chk("to_done_cycles", done_n, 1);
    chk("to_load_kept", bus.LOAD_DATA, 32'hDEAD_BEEF);
    chk("to_state_idle", DBG_STATE, 0);

    // reset during the second REQ cycle, ack arrives afterwards
    clr_cnt();
    drive(2'b11, 2'b00, 32'h80, 32'h0);
    exp_q.push_back(32'h80);
    tick(2);
    RESET = 1'b0;
    idle_in();
    tick(1);
    chk("rr_mem_req", bus.MEM_REQ, 0);
    chk("rr_load", bus.LOAD_DATA, 0);
    chk("rr_state", DBG_STATE, 0);
    RESET = 1'b1;
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 32'hAAAA_5555;
    tick(1);
    idle_in();
    chk("rr_load_after_ack", bus.LOAD_DATA, 0);
    chk("rr_req_after_ack", bus.MEM_REQ, 0);
    tick(2);

    // stray ack in IDLE, half store, access offered during DONE is ignored
    clr_cnt();
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 32'h77;
    tick(1);
    idle_in();
    drive(2'b00, 2'b10, 32'h202, 32'hBEEF);
    exp_q.push_back(32'h202);
    tick(1);
    idle_in();
    bus.MEM_ACK = 1'b1;
    tick(1);
    drive(2'b11, 2'b00, 32'h300, 32'h0);
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 32'h999;
    tick(1);
    idle_in();
    tick(2);
    chk("hs_req_cycles", req_hi, 1);
    chk("hs_load", bus.LOAD_DATA, 0);
    chk("hs_size", bus.MEM_SIZE, 2'b10);

    // byte load at odd address
    clr_cnt();
    drive(2'b01, 2'b00, 32'h307, 32'h0);
    exp_q.push_back(32'h307);
    tick(1);
    idle_in();
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 32'h0000_00A5;
    tick(1);
    idle_in();
    tick(2);
    chk("bl_load", bus.LOAD_DATA, 32'hA5);
    chk("bl_stall_cycles", stall_hi, 1);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
